// File: rtl/store_buffer.sv
// store_buffer: RV32 store formatting (SB/SH/SW) into byte lanes plus a small
// FIFO that drains to data memory over a valid/ready handshake.
// Misaligned or illegal-width stores are consumed and dropped with st_err.
// Optional feature macro: STORE_FWD_EN enables a combinational store-to-load
// forwarding lookup (youngest matching word wins, no byte merging).
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_funct3,
    input  logic [31:0]            in_addr,
    input  logic [31:0]            in_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   st_err,
    output logic [$clog2(DEPTH):0] count,
    input  logic [31:0]            ld_addr,
    output logic                   fwd_hit,
    output logic [31:0]            fwd_data,
    output logic [3:0]             fwd_be
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_err_q, st_err_d;

    logic [29:0]   ent_addr_q  [DEPTH];
    logic [29:0]   ent_addr_d  [DEPTH];
    logic [31:0]   ent_wdata_q [DEPTH];
    logic [31:0]   ent_wdata_d [DEPTH];
    logic [3:0]    ent_be_q    [DEPTH];
    logic [3:0]    ent_be_d    [DEPTH];

    logic          fmt_ok;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic          accept;
    logic          push;
    logic          pop;

    // A full buffer never accepts, even when the head is popping this cycle.
    assign in_ready  = !rst && (count_q < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && fmt_ok;
    assign mem_valid = (count_q != '0);
    assign pop       = mem_valid && mem_ready;

    assign mem_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = ent_wdata_q[rd_ptr_q];
    assign mem_be    = ent_be_q[rd_ptr_q];
    assign st_err    = st_err_q;
    assign count     = count_q;

    // Align rs2 data into byte lanes and flag misaligned / illegal widths.
    always_comb begin
        fmt_ok    = 1'b0;
        fmt_be    = 4'b0000;
        fmt_wdata = 32'h0;
        case (in_funct3)
            3'b000: begin
                fmt_ok    = 1'b1;
                fmt_be    = 4'b0001 << in_addr[1:0];
                fmt_wdata = {4{in_data[7:0]}};
            end
            3'b001: begin
                fmt_ok    = !in_addr[0];
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{in_data[15:0]}};
            end
            3'b010: begin
                fmt_ok    = (in_addr[1:0] == 2'b00);
                fmt_be    = 4'b1111;
                fmt_wdata = in_data;
            end
            default: begin
                fmt_ok    = 1'b0;
            end
        endcase
    end

    // Pointer, occupancy and error-pulse next-state logic.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        st_err_d = accept && !fmt_ok;
    end

    // Entry storage next-state: only the slot at the write pointer changes.
    always_comb begin
        ent_addr_d  = ent_addr_q;
        ent_wdata_d = ent_wdata_q;
        ent_be_d    = ent_be_q;
        if (push) begin
            ent_addr_d[wr_ptr_q]  = in_addr[31:2];
            ent_wdata_d[wr_ptr_q] = fmt_wdata;
            ent_be_d[wr_ptr_q]    = fmt_be;
        end
    end

    // Control state with synchronous reset; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
        end
    end

    // Entry payload registers; contents are meaningless until counted valid.
    always_ff @(posedge clk) begin
        ent_addr_q  <= ent_addr_d;
        ent_wdata_q <= ent_wdata_d;
        ent_be_q    <= ent_be_d;
    end

`ifdef STORE_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        fwd_be   = 4'b0000;
        fwd_idx  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            if ((CW'(i) < count_q) && (ent_addr_q[fwd_idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_wdata_q[fwd_idx];
                fwd_be   = ent_be_q[fwd_idx];
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = 32'h0;
    assign fwd_be         = 4'b0000;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors for store formatting, plus hand-written
// sequences for backpressure, pointer wrap, forwarding and mid-drain reset.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        st_err;
    logic [2:0]  count;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_data(in_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .st_err(st_err), .count(count),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_be(fwd_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ok;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    vec_t vecs[9];
    ent_t model[$];
    int   nVec = 0;
    int   nErr = 0;
    bit   accepted;

    // Compare one value and report a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference store formatting derived from the RV32 store rules.
    function automatic void expFormat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                      output logic ok, output logic [3:0] be, output logic [31:0] wd);
        ok = 1'b0; be = 4'b0000; wd = 32'h0;
        if (f3 == 3'b000) begin
            ok = 1'b1; wd = {4{d[7:0]}};
            be = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                 (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
        end else if (f3 == 3'b001) begin
            ok = (a[0] == 1'b0); wd = {2{d[15:0]}};
            be = a[1] ? 4'b1100 : 4'b0011;
        end else if (f3 == 3'b010) begin
            ok = (a[1:0] == 2'b00); wd = d; be = 4'b1111;
        end
    endfunction

    // One clock with scoreboard checks; inputs must already be driven.
    task automatic applyStimulus();
        logic        ok;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          doPop;
        ent_t        e;
        #1;
        checkOutput("count", 32'(count), 32'(model.size()));
        checkOutput("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
        checkOutput("in_ready", 32'(in_ready), 32'(model.size() < DEPTH));
        checkOutput("mem_valid", 32'(mem_valid), 32'(model.size() != 0));
        if (model.size() != 0) begin
            checkOutput("mem_addr", mem_addr, model[0].addr);
            checkOutput("mem_wdata", mem_wdata, model[0].wdata);
            checkOutput("mem_be", 32'(mem_be), 32'(model[0].be));
        end
        doPop    = mem_ready && (model.size() != 0);
        accepted = in_valid && (model.size() < DEPTH);
        expFormat(in_funct3, in_addr, in_data, ok, be, wd);
        if (doPop) void'(model.pop_front());
        if (accepted && ok) begin
            e.addr = {in_addr[31:2], 2'b00}; e.wdata = wd; e.be = be;
            model.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Push n SW stores, stalling memory for a while or toggling ready, until drained.
    task automatic runStores(input int n, input logic [31:0] base, input int stall, input bit toggle);
        int k = 0;
        int cyc = 0;
        in_funct3 = 3'b010;
        while ((k < n || model.size() != 0) && cyc < 200) begin
            in_valid  = (k < n);
            in_addr   = base + 32'(4 * k);
            in_data   = 32'hC0DE0000 ^ base ^ 32'(k);
            mem_ready = (cyc < stall) ? 1'b0 : (toggle ? cyc[0] : 1'b1);
            applyStimulus();
            if (accepted) k++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("store_seq_done", 32'((k == n) && (model.size() == 0)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b1, 4'b1000, 32'hA5A5_A5A5};
        vecs[1] = '{3'b001, 32'h0000_2002, 32'h0000_1234, 1'b1, 4'b1100, 32'h1234_1234};
        vecs[2] = '{3'b001, 32'h0000_2001, 32'h0000_1234, 1'b0, 4'b0000, 32'h0};
        vecs[3] = '{3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF};
        vecs[4] = '{3'b010, 32'h0000_4002, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0};
        vecs[5] = '{3'b011, 32'h0000_5000, 32'h1111_2222, 1'b0, 4'b0000, 32'h0};
        vecs[6] = '{3'b000, 32'h0000_6000, 32'hFFFF_FF5A, 1'b1, 4'b0001, 32'h5A5A_5A5A};
        vecs[7] = '{3'b001, 32'h0000_7000, 32'hABCD_9876, 1'b1, 4'b0011, 32'h9876_9876};
        vecs[8] = '{3'b000, 32'h0000_8002, 32'h0000_003C, 1'b1, 4'b0100, 32'h3C3C_3C3C};

        rst = 1'b1; in_valid = 1'b0; in_funct3 = 3'b000; in_addr = 32'h0;
        in_data = 32'h0; mem_ready = 1'b1; ld_addr = 32'h0;
        @(posedge clk); #1;
        checkOutput("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("reset_st_err", 32'(st_err), 32'd0);
        checkOutput("reset_fwd_hit", 32'(fwd_hit), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_funct3 = vecs[i].f3;
            in_addr = vecs[i].addr; in_data = vecs[i].data;
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            checkOutput("vec_mem_valid", 32'(mem_valid), 32'(vecs[i].ok));
            checkOutput("vec_st_err", 32'(st_err), 32'(!vecs[i].ok));
            checkOutput("vec_count", 32'(count), 32'(vecs[i].ok));
            if (vecs[i].ok) begin
                checkOutput("vec_mem_addr", mem_addr, {vecs[i].addr[31:2], 2'b00});
                checkOutput("vec_mem_be", 32'(mem_be), 32'(vecs[i].be));
                checkOutput("vec_mem_wdata", mem_wdata, vecs[i].wdata);
            end
            @(posedge clk); #1;
            checkOutput("vec_drained_count", 32'(count), 32'd0);
            checkOutput("vec_st_err_cleared", 32'(st_err), 32'd0);
            checkOutput("vec_mem_valid_low", 32'(mem_valid), 32'd0);
        end

        // Backpressure: five SW with memory stalled, then drain in order.
        runStores(5, 32'h0000_0100, 8, 1'b0);
        // Wrap: ten SW with mem_ready toggling each cycle.
        runStores(10, 32'h0000_0200, 0, 1'b1);

        // Forwarding: two overlapping stores held in the buffer.
        mem_ready = 1'b0;
        in_valid = 1'b1; in_funct3 = 3'b010; in_addr = 32'h0000_3000; in_data = 32'h1111_1111;
        applyStimulus();
        in_funct3 = 3'b000; in_addr = 32'h0000_3001; in_data = 32'h0000_0022;
        applyStimulus();
        in_valid = 1'b0;
        ld_addr = 32'h0000_3002;
        #1;
`ifdef STORE_FWD_EN
        checkOutput("fwd_hit", 32'(fwd_hit), 32'd1);
        checkOutput("fwd_be", 32'(fwd_be), 32'(4'b0010));
        checkOutput("fwd_data", fwd_data, 32'h2222_2222);
`else
        checkOutput("fwd_hit_off", 32'(fwd_hit), 32'd0);
        checkOutput("fwd_data_off", fwd_data, 32'h0);
        checkOutput("fwd_be_off", 32'(fwd_be), 32'd0);
`endif
        ld_addr = 32'h0000_3004;
        #1;
        checkOutput("fwd_miss", 32'(fwd_hit), 32'd0);

        // Third entry queued, then reset mid-drain.
        in_valid = 1'b1; in_funct3 = 3'b010; in_addr = 32'h0000_9000; in_data = 32'h9999_0000;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("pre_reset_count", 32'(count), 32'd3);
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("in_ready_rst_high", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("post_reset_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("post_reset_count", 32'(count), 32'd0);
        rst = 1'b0;
        model.delete();
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
